// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial link peer: FSM state encodings and
// framing constants used by the RX and TX paths.
package serial_link_pkg;

    // Default bit period: 50 MHz system clock at 115200 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    // Start bit + 8 data bits + stop bit.
    localparam int FRAME_BITS = 10;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_OFFER = 3'd1,
        TX_START = 3'd2,
        TX_DATA  = 3'd3,
        TX_STOP  = 3'd4
    } tx_state_t;

endpackage

// File: rtl/serial_peer_fifo.sv
// First-word-fall-through byte FIFO for bytes received from the CPU.
// Pointers carry one extra MSB so full and empty can be told apart.
module serial_peer_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO still lands when the head is popped in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);

    // Status flags from pointer comparison.
    always_comb begin
        empty = (wr_ptr_reg == rd_ptr_reg);
        full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    end

    // Head of queue is visible without a read request.
    assign dout = mem[rd_ptr_reg[AW-1:0]];

    // Storage write; contents need no reset because empty masks them.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

    // Pointer advance.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/serial_link_peer.sv
// Far-end partner of the CPU serial link: 8N1 UART receiver feeding a
// byte FIFO, and a UART transmitter that only starts once the CPU signals
// it is waiting for a byte. RX and TX run independently.
module serial_link_peer
    import serial_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic       tx,
    input  logic       cpu_sig_send,
    input  logic       cpu_sig_recv,
    output logic       peer_sig_send,
    output logic       peer_sig_recv,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_overflow,
    output logic       frame_error
);

    localparam int          BW      = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BIT_M1  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] HALF_M1 = BW'(CLKS_PER_BIT / 2 - 1);

    // ---------------- RX path ----------------
    logic          rx_meta_reg, rx_sync_reg, rx_prev_reg;
    rx_state_t     rx_state_reg, rx_state_next;
    logic [BW-1:0] rx_baud_reg, rx_baud_next;
    logic [3:0]    rx_bits_reg, rx_bits_next;
    logic [7:0]    rx_shift_reg, rx_shift_next;
    logic          rx_push_reg, rx_push_next;
    logic          rx_ferr_reg, rx_ferr_next;
    logic          overflow_reg;

    logic          fifo_pop, fifo_empty, fifo_full;
    logic [7:0]    fifo_dout;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection; idles high.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    // RX state and datapath registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_state_reg <= RX_IDLE;
            rx_baud_reg  <= '0;
            rx_bits_reg  <= '0;
            rx_shift_reg <= '0;
            rx_push_reg  <= 1'b0;
            rx_ferr_reg  <= 1'b0;
        end else begin
            rx_state_reg <= rx_state_next;
            rx_baud_reg  <= rx_baud_next;
            rx_bits_reg  <= rx_bits_next;
            rx_shift_reg <= rx_shift_next;
            rx_push_reg  <= rx_push_next;
            rx_ferr_reg  <= rx_ferr_next;
        end
    end

    // RX next state: start detect, mid-bit sampling, stop-bit check.
    always_comb begin
        rx_state_next = rx_state_reg;
        rx_baud_next  = rx_baud_reg;
        rx_bits_next  = rx_bits_reg;
        rx_shift_next = rx_shift_reg;
        rx_push_next  = 1'b0;
        rx_ferr_next  = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                rx_baud_next = '0;
                rx_bits_next = '0;
                if (rx_prev_reg && !rx_sync_reg) rx_state_next = RX_START;
            end
            RX_START: begin
                if (rx_baud_reg == HALF_M1) begin
                    rx_baud_next  = '0;
                    // Line back high at mid start bit means a glitch, not a frame.
                    rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
                end else begin
                    rx_baud_next = rx_baud_reg + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_baud_reg == BIT_M1) begin
                    rx_baud_next  = '0;
                    rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
                    rx_bits_next  = rx_bits_reg + 4'd1;
                    if (rx_bits_reg == 4'd7) rx_state_next = RX_STOP;
                end else begin
                    rx_baud_next = rx_baud_reg + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_baud_reg == BIT_M1) begin
                    rx_baud_next  = '0;
                    rx_push_next  = rx_sync_reg;
                    rx_ferr_next  = !rx_sync_reg;
                    rx_state_next = RX_IDLE;
                end else begin
                    rx_baud_next = rx_baud_reg + 1'b1;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    // Sticky overflow: a completed byte found the FIFO full with no pop to make room.
    always_ff @(posedge clock) begin
        if (!reset) begin
            overflow_reg <= 1'b0;
        end else if (rx_push_reg && fifo_full && !fifo_pop) begin
            overflow_reg <= 1'b1;
        end
    end

    assign fifo_pop = rx_valid && rx_ready;

    serial_peer_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (rx_push_reg),
        .pop   (fifo_pop),
        .din   (rx_shift_reg),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // RX-side outputs; cpu_sig_send is deliberately OR'd away so it never gates acceptance.
    always_comb begin
        peer_sig_send = !fifo_full && (rx_state_reg == RX_IDLE) && (cpu_sig_send || 1'b1);
        rx_valid      = !fifo_empty;
        rx_data       = fifo_empty ? 8'h00 : fifo_dout;
        rx_overflow   = overflow_reg;
        frame_error   = rx_ferr_reg;
    end

    // ---------------- TX path ----------------
    tx_state_t     tx_state_reg, tx_state_next;
    logic [BW-1:0] tx_baud_reg, tx_baud_next;
    logic [3:0]    tx_bits_reg, tx_bits_next;
    logic [7:0]    tx_shift_reg, tx_shift_next;

    // TX state and datapath registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tx_state_reg <= TX_IDLE;
            tx_baud_reg  <= '0;
            tx_bits_reg  <= '0;
            tx_shift_reg <= '0;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_baud_reg  <= tx_baud_next;
            tx_bits_reg  <= tx_bits_next;
            tx_shift_reg <= tx_shift_next;
        end
    end

    // TX next state: latch byte, wait for CPU, then shift out one full frame.
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_baud_next  = tx_baud_reg;
        tx_bits_next  = tx_bits_reg;
        tx_shift_next = tx_shift_reg;
        case (tx_state_reg)
            TX_IDLE: begin
                tx_baud_next = '0;
                tx_bits_next = '0;
                if (tx_valid) begin
                    tx_shift_next = tx_data;
                    tx_state_next = TX_OFFER;
                end
            end
            TX_OFFER: begin
                tx_baud_next = '0;
                if (cpu_sig_recv) tx_state_next = TX_START;
            end
            TX_START: begin
                if (tx_baud_reg == BIT_M1) begin
                    tx_baud_next  = '0;
                    tx_state_next = TX_DATA;
                end else begin
                    tx_baud_next = tx_baud_reg + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_baud_reg == BIT_M1) begin
                    tx_baud_next  = '0;
                    tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                    tx_bits_next  = tx_bits_reg + 4'd1;
                    if (tx_bits_reg == 4'd7) tx_state_next = TX_STOP;
                end else begin
                    tx_baud_next = tx_baud_reg + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_baud_reg == BIT_M1) begin
                    tx_baud_next  = '0;
                    tx_state_next = TX_IDLE;
                end else begin
                    tx_baud_next = tx_baud_reg + 1'b1;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    // TX-side outputs decoded from state; line idles high outside START/DATA.
    always_comb begin
        tx_ready      = (tx_state_reg == TX_IDLE);
        peer_sig_recv = (tx_state_reg != TX_IDLE);
        case (tx_state_reg)
            TX_START: tx = 1'b0;
            TX_DATA:  tx = tx_shift_reg[0];
            default:  tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_serial_link_peer.sv
// Directed testbench for serial_link_peer at 4 clocks per bit, 4-entry FIFO.
module tb_serial_link_peer;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       tx;
    logic       cpu_sig_send;
    logic       cpu_sig_recv;
    logic       peer_sig_send;
    logic       peer_sig_recv;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_overflow;
    logic       frame_error;

    int total = 0;
    int bad   = 0;
    int fe_count = 0;

    serial_link_peer #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clock         (clk),
        .reset         (reset),
        .rx            (rx),
        .tx            (tx),
        .cpu_sig_send  (cpu_sig_send),
        .cpu_sig_recv  (cpu_sig_recv),
        .peer_sig_send (peer_sig_send),
        .peer_sig_recv (peer_sig_recv),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_overflow   (rx_overflow),
        .frame_error   (frame_error)
    );

    always #5 clk = ~clk;

    // Count frame_error pulses seen on rising edges.
    always @(posedge clk) begin
        if (frame_error) fe_count <= fe_count + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("chk %s ok val=%0h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one 8N1 frame onto rx, LSB first; stop_bit lets a bad stop be forced.
    task automatic send_rx(input logic [7:0] d, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            tick(CPB);
        end
        rx = 1'b1;
    endtask

    // Called one cycle into START; samples tx at the middle of each of the 10 bits.
    task automatic cap_tx(output logic [9:0] bits);
        bits = '0;
        tick(CPB / 2);
        for (int i = 0; i < 10; i++) begin
            bits[i] = tx;
            if (i < 9) tick(CPB);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [9:0] bits;
        int lat;
        int fe0;

        reset = 1'b0; rx = 1'b1; cpu_sig_send = 1'b0; cpu_sig_recv = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(2);

        // 1. idle after reset
        chk("rst_tx",        32'(tx),            32'd1);
        chk("rst_tx_ready",  32'(tx_ready),      32'd1);
        chk("rst_psend",     32'(peer_sig_send), 32'd1);
        chk("rst_precv",     32'(peer_sig_recv), 32'd0);
        chk("rst_rx_valid",  32'(rx_valid),      32'd0);

        // 2. receive A5
        cpu_sig_send = 1'b1;
        send_rx(8'hA5, 1'b1);
        cpu_sig_send = 1'b0;
        lat = 40;
        while (!rx_valid && lat < 50) begin
            tick(1);
            lat++;
        end
        chk("rx_a5_latency_ok", 32'(lat <= 42), 32'd1);
        chk("rx_a5_valid",      32'(rx_valid),  32'd1);
        chk("rx_a5_data",       32'(rx_data),   32'hA5);
        chk("rx_a5_no_ferr",    32'(fe_count),  32'd0);
        rx_ready = 1'b1; tick(1); rx_ready = 1'b0;
        chk("rx_a5_popped",     32'(rx_valid),  32'd0);

        // 3. transmit 3C after CPU asks; CPU drops recv early, frame must finish
        tx_data = 8'h3C; tx_valid = 1'b1; tick(1); tx_valid = 1'b0;
        chk("tx_offer_precv",  32'(peer_sig_recv), 32'd1);
        chk("tx_offer_ready",  32'(tx_ready),      32'd0);
        tick(5);
        chk("tx_offer_line",   32'(tx),            32'd1);
        cpu_sig_recv = 1'b1; tick(1); cpu_sig_recv = 1'b0;
        cap_tx(bits);
        chk("tx_3c_bits",      32'(bits),          32'(10'b1001111000));
        tick(3);
        chk("tx_3c_ready",     32'(tx_ready),      32'd1);
        chk("tx_3c_precv",     32'(peer_sig_recv), 32'd0);

        // 4. fill FIFO, overflow on the fifth byte
        for (int v = 1; v <= 5; v++) begin
            send_rx(8'(v), 1'b1);
            tick(2);
            if (v <= 4) chk($sformatf("fill_psend_%0d", v), 32'(peer_sig_send), 32'(v < 4));
        end
        chk("ovf_sticky", 32'(rx_overflow), 32'd1);
        for (int v = 1; v <= 4; v++) begin
            chk($sformatf("pop_%0d", v), 32'(rx_data), 32'(v));
            rx_ready = 1'b1; tick(1); rx_ready = 1'b0;
        end
        chk("pop_empty", 32'(rx_valid), 32'd0);

        // 5. bad stop bit, then a one-cycle glitch
        fe0 = fe_count;
        send_rx(8'hFF, 1'b0);
        tick(4);
        chk("ferr_one_pulse", 32'(fe_count - fe0), 32'd1);
        chk("ferr_no_push",   32'(rx_valid),       32'd0);
        rx = 1'b0; tick(1); rx = 1'b1;
        tick(12);
        chk("glitch_no_ferr", 32'(fe_count - fe0), 32'd1);
        chk("glitch_no_push", 32'(rx_valid),       32'd0);
        chk("glitch_psend",   32'(peer_sig_send),  32'd1);

        // 6. reset during a TX start bit
        tx_data = 8'h99; tx_valid = 1'b1; tick(1); tx_valid = 1'b0;
        cpu_sig_recv = 1'b1; tick(2);
        chk("mid_tx_low", 32'(tx), 32'd0);
        reset = 1'b0; tick(1);
        chk("mreset_tx",       32'(tx),            32'd1);
        chk("mreset_tx_ready", 32'(tx_ready),      32'd1);
        chk("mreset_psend",    32'(peer_sig_send), 32'd1);
        chk("mreset_precv",    32'(peer_sig_recv), 32'd0);
        chk("mreset_rx_valid", 32'(rx_valid),      32'd0);
        chk("mreset_rx_data",  32'(rx_data),       32'd0);
        chk("mreset_ovf",      32'(rx_overflow),   32'd0);
        chk("mreset_ferr",     32'(frame_error),   32'd0);
        reset = 1'b1; cpu_sig_recv = 1'b0;
        tick(2);

        // full duplex: RX 5A while TX C3
        tx_data = 8'hC3; tx_valid = 1'b1; tick(1); tx_valid = 1'b0;
        cpu_sig_recv = 1'b1; tick(1); cpu_sig_recv = 1'b0;
        fork
            send_rx(8'h5A, 1'b1);
            cap_tx(bits);
        join
        tick(4);
        chk("dup_tx_bits",  32'(bits),     32'({1'b1, 8'hC3, 1'b0}));
        chk("dup_rx_valid", 32'(rx_valid), 32'd1);
        chk("dup_rx_data",  32'(rx_data),  32'h5A);
        chk("dup_tx_ready", 32'(tx_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
